// File: rtl/pipe_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_wb_reg
// Brief    : Multi-lane MEM->WB pipeline register with flush, WAW arbitration,
//            x0 suppression and saturating bubble/hold counters.
// Revision : 1.0
// ============================================================================
module pipe_wb_reg #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int STALL_W   = 6,
    parameter int STAGE     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [STALL_W-1:0]            stall,
    input  logic                          flush,
    input  logic                          clr_cnt,
    input  logic [NUM_LANES-1:0]          in_w_enable,
    input  logic [NUM_LANES*ADDR_W-1:0]   in_w_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   in_w_data,
    output logic [NUM_LANES-1:0]          out_w_enable,
    output logic [NUM_LANES*ADDR_W-1:0]   out_w_addr,
    output logic [NUM_LANES*DATA_W-1:0]   out_w_data,
    output logic [CNT_W-1:0]              bubble_cnt,
    output logic [CNT_W-1:0]              hold_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic                        w_own;
    logic                        w_down;
    logic                        w_nop;
    logic                        w_hold;
    logic                        w_unused_stall;
    logic [NUM_LANES-1:0]        w_eff;
    logic [NUM_LANES*ADDR_W-1:0] w_nxt_addr;
    logic [NUM_LANES*DATA_W-1:0] w_nxt_data;

    logic [NUM_LANES-1:0]        r_en;
    logic [NUM_LANES*ADDR_W-1:0] r_addr;
    logic [NUM_LANES*DATA_W-1:0] r_data;
    logic [CNT_W-1:0]            r_bubble_cnt;
    logic [CNT_W-1:0]            r_hold_cnt;

    assign w_own = stall[STAGE];

    // The last stage has no downstream neighbour, so it can never be held.
    generate
        if (STAGE == STALL_W - 1) begin : g_last_stage
            assign w_down = 1'b0;
        end else begin : g_mid_stage
            assign w_down = stall[STAGE+1];
        end
    endgenerate

    assign w_unused_stall = ^stall;

    assign w_nop  = flush || (w_own && !w_down);
    assign w_hold = !flush && w_own && w_down;

    // A lane survives unless its target is x0 or a higher lane writes the same register.
    always_comb begin
        w_eff = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_eff[i] = in_w_enable[i] && (in_w_addr[i*ADDR_W +: ADDR_W] != '0);
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (in_w_enable[j] &&
                    (in_w_addr[j*ADDR_W +: ADDR_W] == in_w_addr[i*ADDR_W +: ADDR_W])) begin
                    w_eff[i] = 1'b0;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            assign w_nxt_addr[g*ADDR_W +: ADDR_W] = w_eff[g] ? in_w_addr[g*ADDR_W +: ADDR_W] : '0;
            assign w_nxt_data[g*DATA_W +: DATA_W] = w_eff[g] ? in_w_data[g*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en   <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_nop) begin
            r_en   <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else if (!w_own) begin
            r_en   <= w_eff;
            r_addr <= w_nxt_addr;
            r_data <= w_nxt_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else if (clr_cnt) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else if (w_nop) begin
            if (r_bubble_cnt != c_cnt_max) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (w_hold) begin
            if (r_hold_cnt != c_cnt_max) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    assign out_w_enable = r_en;
    assign out_w_addr   = r_addr;
    assign out_w_data   = r_data;
    assign bubble_cnt   = r_bubble_cnt;
    assign hold_cnt     = r_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_wb_reg
// Brief    : Directed plus randomized self-checking bench for pipe_wb_reg.
// Revision : 1.0
// ============================================================================
module tb_pipe_wb_reg;

    localparam int NL  = 2;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int SW  = 6;
    localparam int STG = 4;
    localparam int CW  = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [SW-1:0]     stall = '0;
    logic              flush = 1'b0;
    logic              clr_cnt = 1'b0;
    logic [NL-1:0]     in_w_enable = '0;
    logic [NL*AW-1:0]  in_w_addr = '0;
    logic [NL*DW-1:0]  in_w_data = '0;
    logic [NL-1:0]     out_w_enable;
    logic [NL*AW-1:0]  out_w_addr;
    logic [NL*DW-1:0]  out_w_data;
    logic [CW-1:0]     bubble_cnt;
    logic [CW-1:0]     hold_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [NL-1:0]    m_en;
    logic [NL*AW-1:0] m_addr;
    logic [NL*DW-1:0] m_data;
    int               m_bub;
    int               m_hold;

    pipe_wb_reg #(
        .NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW),
        .STALL_W(SW), .STAGE(STG), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_w_enable(in_w_enable), .in_w_addr(in_w_addr), .in_w_data(in_w_data),
        .out_w_enable(out_w_enable), .out_w_addr(out_w_addr), .out_w_data(out_w_data),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".en"},   64'(out_w_enable), 64'(m_en));
        chk({tag, ".addr"}, 64'(out_w_addr),   64'(m_addr));
        chk({tag, ".data"}, 64'(out_w_data),   64'(m_data));
        chk({tag, ".bub"},  64'(bubble_cnt),   64'(m_bub));
        chk({tag, ".hold"}, 64'(hold_cnt),     64'(m_hold));
    endtask

    task automatic model_reset();
        m_en = '0; m_addr = '0; m_data = '0; m_bub = 0; m_hold = 0;
    endtask

    // Register-file view: for each target register the last enabled lane is the writer.
    task automatic model_edge(input logic [SW-1:0] st, input logic fl, input logic clr,
                              input logic [NL-1:0] en, input logic [NL*AW-1:0] ad,
                              input logic [NL*DW-1:0] da);
        int  writer [32];
        bit  own, down, nop, hold;
        own  = st[STG];
        down = (STG == SW - 1) ? 1'b0 : st[STG+1];
        nop  = fl || (own && !down);
        hold = !fl && own && down;
        if (nop) begin
            m_en = '0; m_addr = '0; m_data = '0;
        end else if (!own) begin
            for (int r = 0; r < 32; r++) writer[r] = -1;
            for (int i = 0; i < NL; i++)
                if (en[i]) writer[int'(ad[i*AW +: AW])] = i;
            m_en = '0; m_addr = '0; m_data = '0;
            for (int r = 1; r < 32; r++) begin
                if (writer[r] >= 0) begin
                    m_en[writer[r]] = 1'b1;
                    m_addr[writer[r]*AW +: AW] = AW'(r);
                    m_data[writer[r]*DW +: DW] = da[writer[r]*DW +: DW];
                end
            end
        end
        if (clr) begin
            m_bub = 0; m_hold = 0;
        end else if (nop) begin
            m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
        end else if (hold) begin
            m_hold = (m_hold < CMAX) ? m_hold + 1 : CMAX;
        end
    endtask

    task automatic step(input string tag, input logic [SW-1:0] st, input logic fl,
                        input logic clr, input logic [NL-1:0] en,
                        input logic [NL*AW-1:0] ad, input logic [NL*DW-1:0] da);
        @(negedge clk);
        stall = st; flush = fl; clr_cnt = clr;
        in_w_enable = en; in_w_addr = ad; in_w_data = da;
        @(posedge clk);
        #1;
        model_edge(st, fl, clr, en, ad, da);
        chk_all(tag);
    endtask

    initial begin
        logic [SW-1:0]    r_st;
        logic             r_fl, r_clr;
        logic [NL-1:0]    r_en;
        logic [NL*AW-1:0] r_ad;
        logic [NL*DW-1:0] r_da;
        int               sel;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1. asynchronous reset mid-operation
        step("t1_load", 6'b0, 1'b0, 1'b0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hAAAA5555});
        chk("t1_loaded_en", 64'(out_w_enable), 64'h1);
        #1;
        in_w_enable = 2'b11; in_w_addr = {5'd6, 5'd5};
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("t1_async");
        @(posedge clk);
        #1;
        chk_all("t1_held_in_reset");
        @(negedge clk);
        rst = 1'b1;

        // 2. WAW: higher lane wins
        step("t2", 6'b0, 1'b0, 1'b0, 2'b11, {5'd7, 5'd7}, {32'h22, 32'h11});
        chk("t2_en_lit", 64'(out_w_enable), 64'h2);
        chk("t2_addr_lit", 64'(out_w_addr), 64'({5'd7, 5'd0}));
        chk("t2_data_lit", 64'(out_w_data), 64'({32'h22, 32'h0}));

        // 3. x0 suppression and disabled lane
        step("t3", 6'b0, 1'b0, 1'b0, 2'b01, {5'd9, 5'd0}, {32'h33, 32'hFF});
        chk("t3_en_lit", 64'(out_w_enable), 64'h0);
        chk("t3_data_lit", 64'(out_w_data), 64'h0);

        // 4. hold, bubble, then advance
        step("t4_load", 6'b0, 1'b0, 1'b1, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h44});
        for (int k = 0; k < 3; k++)
            step("t4_hold", 6'b110000, 1'b0, 1'b0, 2'b11, {5'd1, 5'd2}, {32'h9, 32'h8});
        chk("t4_hold_lit", 64'(hold_cnt), 64'd3);
        chk("t4_held_data", 64'(out_w_data), 64'({32'h0, 32'h44}));
        step("t4_bubble", 6'b010000, 1'b0, 1'b0, 2'b11, {5'd1, 5'd2}, {32'h9, 32'h8});
        chk("t4_bub_lit", 64'(bubble_cnt), 64'd1);
        step("t4_adv", 6'b0, 1'b0, 1'b0, 2'b11, {5'd1, 5'd2}, {32'h9, 32'h8});

        // 5. flush beats stall
        step("t5_hold", 6'b110000, 1'b0, 1'b0, 2'b00, '0, '0);
        step("t5_flush", 6'b110000, 1'b1, 1'b0, 2'b11, {5'd3, 5'd4}, {32'h5, 32'h6});
        chk("t5_en_lit", 64'(out_w_enable), 64'h0);

        // 6. saturation and clear priority
        step("t6_clr", 6'b0, 1'b0, 1'b1, 2'b00, '0, '0);
        for (int k = 0; k < 9; k++)
            step("t6_bub", 6'b010000, 1'b0, 1'b0, 2'b00, '0, '0);
        chk("t6_sat_lit", 64'(bubble_cnt), 64'd7);
        step("t6_clr_bub", 6'b010000, 1'b0, 1'b1, 2'b00, '0, '0);
        chk("t6_clr_lit", 64'(bubble_cnt), 64'd0);

        // last stage of the vector unconnected: random upper bit only matters at STAGE+1
        for (int n = 0; n < 400; n++) begin
            sel   = int'($urandom_range(0, 9));
            r_st  = SW'($urandom);
            if (sel < 6)       r_st[STG] = 1'b0;
            else if (sel < 8)  begin r_st[STG] = 1'b1; r_st[STG+1] = 1'b1; end
            else               begin r_st[STG] = 1'b1; r_st[STG+1] = 1'b0; end
            r_fl  = ($urandom_range(0, 11) == 0);
            r_clr = ($urandom_range(0, 19) == 0);
            r_en  = NL'($urandom);
            r_ad  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            r_da  = {$urandom, $urandom};
            step("rand", r_st, r_fl, r_clr, r_en, r_ad, r_da);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_wb_reg.md
Name: pipe_wb_reg

Overview:
Parametrised multi-lane MEM→WB pipeline register, successor to the single-lane memory/writeback register. Registers NUM_LANES writeback requests (enable/addr/data) and applies the shared stall-vector rules. Adds the following over the single-lane stage:
- flush input;
- same-cycle write-after-write arbitration between lanes;
- x0 write suppression;
- saturating bubble/hold performance counters.

Sits between the memory stage(s) and the register file write ports.

Parameters:
NUM_LANES, 2, number of parallel writeback lanes (≥1)
DATA_W, 32, register data width
ADDR_W, 5, register address width
STALL_W, 6, width of pipeline stall vector
STAGE, 4, index of this stage's bit in stall (0 ≤ STAGE < STALL_W)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  STALL_W  pipeline stall vector, bit k = stage k stalled
flush  in  1  synchronous squash of this stage's contents
clr_cnt  in  1  synchronous clear of both counters
in_w_enable  in  NUM_LANES  per-lane write enable from memory stage
in_w_addr  in  NUM_LANES*ADDR_W  lane i at bits [i*ADDR_W +: ADDR_W]
in_w_data  in  NUM_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
out_w_enable  out  NUM_LANES  registered per-lane write enable to register file
out_w_addr  out  NUM_LANES*ADDR_W  registered addresses, same packing
out_w_data  out  NUM_LANES*DATA_W  registered data, same packing
bubble_cnt  out  CNT_W  count of cycles a NOP was inserted (bubble or flush)
hold_cnt  out  CNT_W  count of cycles contents were held

Behaviour:
- Reset (rst=0, asynchronous): all out_* = 0; bubble_cnt = 0; hold_cnt = 0. Takes effect immediately, including mid-stall or mid-flush. Release is sampled on the next clk edge.
- Definitions:
  - own = stall[STAGE].
  - down = stall[STAGE+1], forced to 0 when STAGE = STALL_W-1.
- Per rising edge, mutually exclusive, in priority order:
  1. FLUSH (flush=1, regardless of stall): all lanes become canonical NOP (enable=0, addr=0, data=0).
  2. BUBBLE (own=1, down=0): all lanes become canonical NOP.
  3. HOLD (own=1, down=1): outputs keep their value.
  4. ADVANCE (own=0): lanes are loaded from inputs after filtering.
- ADVANCE lane filter (combinational on inputs, registered):
  - eff_i = in_w_enable[i] AND addr_i ≠ 0 AND no j>i with in_w_enable[j]=1 and addr_j = addr_i.
  - WAW rule: the highest-numbered lane wins.
  - eff_i=1: out enable=1, addr/data copied verbatim.
  - eff_i=0: lane output is canonical NOP (addr=0, data=0), never stale values.
- Latency: exactly 1 cycle from input to output on ADVANCE. No combinational path from any input to any output.
- Counters (after reset):
  - clr_cnt=1 → both counters load 0 that edge, overriding any increment.
  - Otherwise bubble_cnt += 1 on FLUSH or BUBBLE cycles.
  - Otherwise hold_cnt += 1 on HOLD cycles.
  - Both saturate at all-ones and never wrap.
  - ADVANCE cycles increment neither counter.
- NUM_LANES=1: WAW logic degenerates to none. Behaviour then equals the single-lane stage plus flush, x0 suppression, counters and async reset.

Test Plan:
1. Reset mid-operation: advance lane0 {en=1, addr=3, data=0xAAAA5555}. Next cycle pull rst=0 between edges → all outputs and counters read 0 before the next edge; outputs stay 0 while rst=0.
2. ADVANCE with WAW: lane0 {1, 7, 0x11}, lane1 {1, 7, 0x22}, stall=0 → after 1 edge: out_w_enable=2'b10, lane1 addr=7 data=0x22, lane0 addr=0 data=0.
3. x0 suppression plus disabled lane: lane0 {1, 0, 0xFF}, lane1 {0, 9, 0x33} → out_w_enable=0, all addr/data 0, hold_cnt and bubble_cnt unchanged.
4. Stall behaviour: load lane0 {1, 4, 0x44}. Then:
   - stall=6'b110000 for 3 edges → output unchanged, hold_cnt=3.
   - stall=6'b010000 for 1 edge → output NOP, bubble_cnt=1.
   - stall=0 with new input → new values appear.
5. Flush overrides stall: valid contents held, stall=6'b110000 and flush=1 → NOP next edge, bubble_cnt +1, hold_cnt unchanged.
6. Saturation/clear: CNT_W=3, 9 BUBBLE edges → bubble_cnt=7. clr_cnt=1 during a BUBBLE edge → bubble_cnt=0.
